tl_sensor_conditioner: RTL and testbench
========================================

// Module: tl_sensor_conditioner
// PURPOSE
//  Front end for the traffic-light controller: conditions the raw EW road-loop and emergency inputs.
//  Synchronises, debounces and qualifies them, then drives the controller's ew_sensor / emgcy_sensor inputs.
//  ew_sensor is a latched car-waiting request, cleared once EW is served (ew_light==GREEN).
//  emgcy_sensor is the debounced emergency level stretched by a hold time.
// PARAMETERS
//  DEBOUNCE_CYCLES    4   consecutive cycles a synced input must differ from its stable value before the stable value flips (>=1)
//  EMGCY_HOLD_CYCLES  8   cycles emgcy_sensor stays high after debounced emergency falls (>=0)
//  CNT_W              4   width of ew_car_count
// PORTS
//  clk           in   1        master clock, rising edge
//  reset_n       in   1        asynchronous, active-low reset
//  ew_loop_raw   in   1        raw EW inductive-loop input, asynchronous to clk
//  emgcy_raw     in   1        raw emergency-vehicle detector, asynchronous to clk
//  ew_light      in   lights_t EW light state fed back from the controller
//  ew_sensor     out  1        EW car-waiting request, to controller
//  emgcy_sensor  out  1        qualified emergency, to controller
//  ew_car_count  out  CNT_W    EW arrivals since last EW green, saturating
//  ew_overflow   out  1        sticky: count saturated since last EW green
// BEHAVIOUR
//  Reset (async assert, sync release): all flops 0; every output 0 immediately on assertion.
//   Reset mid-debounce or mid-hold discards that state; no pulse on release.
//  Per channel: 2-FF synchroniser (s1, s2), then debouncer with a counter and a stable bit.
//   - s2 != stable: counter increments. On the DEBOUNCE_CYCLES-th consecutive increment, stable flips and the counter clears.
//   - s2 == stable: counter clears. Glitches shorter than DEBOUNCE_CYCLES never reach stable.
//  Latency: raw edge first captured at clk edge 0 -> stable flips at edge 1+D -> output registered at edge 2+D (D=DEBOUNCE_CYCLES).
//  EW request FSM, states IDLE / WAIT:
//   - IDLE -> WAIT on rising edge of debounced loop (stable 0->1) while ew_light!=GREEN.
//   - WAIT -> IDLE when ew_light==GREEN.
//   - ew_sensor = (state==WAIT), registered.
//   - Arrival and ew_light==GREEN in the same cycle: GREEN wins; the car passes on green; state IDLE, no count.
//   - Loop held high continuously: exactly one request; a new request needs a debounced fall then rise.
//  ew_car_count: +1 per debounced rising edge while ew_light!=GREEN; saturates at 2^CNT_W-1.
//   - Arrival while saturated sets ew_overflow.
//   - ew_light==GREEN clears count and ew_overflow (clear has priority over increment).
//  Emergency FSM, states QUIET / ACTIVE / HOLD:
//   - QUIET -> ACTIVE on debounced emergency rise.
//   - ACTIVE -> HOLD on debounced fall; hold counter loads EMGCY_HOLD_CYCLES.
//   - HOLD decrements; HOLD -> QUIET when counter==0.
//   - HOLD -> ACTIVE on debounced re-rise; the hold counter is abandoned and reloads on the next fall.
//   - emgcy_sensor = (state != QUIET), registered.
//   - EMGCY_HOLD_CYCLES=0: drops the cycle after the debounced fall.
//  Emergency conditioning is independent of ew_light. EW request FSM keeps its state during an emergency.
//  Hold counter width $clog2(EMGCY_HOLD_CYCLES+1), min 1. Debounce counter width $clog2(DEBOUNCE_CYCLES+1).
// STRUCTURE
//  tlight_pkg: lights_t enum (OFF,RED,YELLOW,GREEN,PRE_GREEN), ew_req_state_t, emgcy_state_t, default parameter constants.
//  Sub-module tl_debounce (params DEBOUNCE_CYCLES): raw in, sync + debounce, outputs stable, rise, fall.
//   Instantiated twice. The top holds both FSMs, the counter and the output registers.
// TESTING
//  T1 reset: reset_n=0 mid-operation with both raws high -> all outputs 0 same cycle; after release, outputs follow first-capture latency.
//  T2 debounce: 3-cycle high glitch on ew_loop_raw, D=4 -> ew_sensor stays 0.
//   Then 10-cycle high pulse -> ew_sensor=1 at edge 6 after capture; ew_car_count=1.
//  T3 service: with ew_sensor=1, set ew_light=GREEN -> ew_sensor=0 and count=0 next edge.
//   Arrival debounced in the same cycle as GREEN -> stays 0.
//  T4 saturation: 16 debounced car pulses while ew_light=RED, CNT_W=4 -> count=15 and ew_overflow=1; GREEN clears both.
//  T5 emergency hold: emgcy_raw high 20 cycles, HOLD=8 -> emgcy_sensor rises at edge D+2, stays high 8 cycles after debounced fall, then 0.
//  T6 re-trigger: emergency re-asserted 3 cycles into HOLD -> emgcy_sensor never drops.
//   Next fall gives the full 8-cycle hold.

Source files
------------

// File: rtl/tlight_pkg.sv
// Shared types and default constants for the traffic-light sensor front end.
package tlight_pkg;

  typedef enum logic [2:0] {
    OFF       = 3'd0,
    RED       = 3'd1,
    YELLOW    = 3'd2,
    GREEN     = 3'd3,
    PRE_GREEN = 3'd4
  } lights_t;

  typedef enum logic {
    EW_IDLE = 1'b0,
    EW_WAIT = 1'b1
  } ew_req_state_t;

  typedef enum logic [1:0] {
    EM_QUIET  = 2'd0,
    EM_ACTIVE = 2'd1,
    EM_HOLD   = 2'd2
  } emgcy_state_t;

  localparam int unsigned DEF_DEBOUNCE_CYCLES   = 4;
  localparam int unsigned DEF_EMGCY_HOLD_CYCLES = 8;
  localparam int unsigned DEF_CNT_W             = 4;

endpackage

// File: rtl/tl_debounce.sv
// Two-flop synchroniser followed by a consecutive-cycle debouncer.
// rise_o/fall_o are single-cycle pulses registered together with the stable flip.
module tl_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_i,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s2_q;
  logic          stable_q, stable_d;
  logic          rise_q, fall_q;
  logic          flip_c;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive disagreements; the last one flips the stable value.
  always_comb begin
    cnt_d  = '0;
    flip_c = 1'b0;
    if (s2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        flip_c = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign stable_d = stable_q ^ flip_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      s1_q     <= raw_i;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_q   <= flip_c & s2_q;
      fall_q   <= flip_c & ~s2_q;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;

endmodule

// File: rtl/tl_sensor_conditioner.sv
// Conditions raw EW loop and emergency inputs into the controller's ew_sensor / emgcy_sensor,
// plus an EW arrival counter with sticky saturation flag.
module tl_sensor_conditioner
  import tlight_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned EMGCY_HOLD_CYCLES = DEF_EMGCY_HOLD_CYCLES,
  parameter int unsigned CNT_W             = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ew_loop_raw,
  input  logic             emgcy_raw,
  input  lights_t          ew_light,
  output logic             ew_sensor,
  output logic             emgcy_sensor,
  output logic [CNT_W-1:0] ew_car_count,
  output logic             ew_overflow
);

  localparam int unsigned HW = (EMGCY_HOLD_CYCLES < 1) ? 1 : $clog2(EMGCY_HOLD_CYCLES + 1);
  localparam logic [HW-1:0]    HOLD_LOAD = HW'(EMGCY_HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic ew_stable, ew_rise, ew_fall;
  logic em_stable, em_rise, em_fall;
  logic unused_dbnc;

  tl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ew_dbnc (
    .clk      (clk),
    .reset_n  (reset_n),
    .raw_i    (ew_loop_raw),
    .stable_o (ew_stable),
    .rise_o   (ew_rise),
    .fall_o   (ew_fall)
  );

  tl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_em_dbnc (
    .clk      (clk),
    .reset_n  (reset_n),
    .raw_i    (emgcy_raw),
    .stable_o (em_stable),
    .rise_o   (em_rise),
    .fall_o   (em_fall)
  );

  assign unused_dbnc = ^{ew_stable, ew_fall, em_stable};

  ew_req_state_t    ew_state_q, ew_state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             green_c, arrival_c;

  // EW request FSM and arrival counter; green service beats a same-cycle arrival.
  always_comb begin
    ew_state_d = ew_state_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    green_c    = (ew_light == GREEN);
    arrival_c  = ew_rise & ~green_c;

    unique case (ew_state_q)
      EW_IDLE: if (arrival_c) ew_state_d = EW_WAIT;
      EW_WAIT: if (green_c)   ew_state_d = EW_IDLE;
      default: ew_state_d = EW_IDLE;
    endcase

    if (green_c) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (arrival_c) begin
      if (count_q == CNT_MAX) begin
        ovf_d = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  emgcy_state_t  em_state_q, em_state_d;
  logic [HW-1:0] hold_q, hold_d;

  // Emergency qualifier: a re-rise during HOLD abandons the countdown.
  always_comb begin
    em_state_d = em_state_q;
    hold_d     = hold_q;

    unique case (em_state_q)
      EM_QUIET: begin
        if (em_rise) em_state_d = EM_ACTIVE;
      end
      EM_ACTIVE: begin
        if (em_fall) begin
          em_state_d = EM_HOLD;
          hold_d     = HOLD_LOAD;
        end
      end
      EM_HOLD: begin
        if (em_rise) begin
          em_state_d = EM_ACTIVE;
        end else if (hold_q == '0) begin
          em_state_d = EM_QUIET;
        end else begin
          hold_d = hold_q - HW'(1);
        end
      end
      default: em_state_d = EM_QUIET;
    endcase
  end

  logic ew_sensor_q, emgcy_sensor_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ew_state_q     <= EW_IDLE;
      count_q        <= '0;
      ovf_q          <= 1'b0;
      em_state_q     <= EM_QUIET;
      hold_q         <= '0;
      ew_sensor_q    <= 1'b0;
      emgcy_sensor_q <= 1'b0;
    end else begin
      ew_state_q     <= ew_state_d;
      count_q        <= count_d;
      ovf_q          <= ovf_d;
      em_state_q     <= em_state_d;
      hold_q         <= hold_d;
      ew_sensor_q    <= (ew_state_d == EW_WAIT);
      emgcy_sensor_q <= (em_state_d != EM_QUIET);
    end
  end

  assign ew_sensor    = ew_sensor_q;
  assign emgcy_sensor = emgcy_sensor_q;
  assign ew_car_count = count_q;
  assign ew_overflow  = ovf_q;

endmodule

// File: tb/tb_tl_sensor_conditioner.sv
// Directed bench for tl_sensor_conditioner with hand-computed cycle expectations (D=4, HOLD=8, CNT_W=4).
module tb_tl_sensor_conditioner;
  import tlight_pkg::*;

  localparam int unsigned CW = 4;

  logic          clk;
  logic          reset_n;
  logic          ew_loop_raw;
  logic          emgcy_raw;
  lights_t       ew_light;
  logic          ew_sensor;
  logic          emgcy_sensor;
  logic [CW-1:0] ew_car_count;
  logic          ew_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  tl_sensor_conditioner #(
    .DEBOUNCE_CYCLES   (4),
    .EMGCY_HOLD_CYCLES (8),
    .CNT_W             (CW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ew_loop_raw  (ew_loop_raw),
    .emgcy_raw    (emgcy_raw),
    .ew_light     (ew_light),
    .ew_sensor    (ew_sensor),
    .emgcy_sensor (emgcy_sensor),
    .ew_car_count (ew_car_count),
    .ew_overflow  (ew_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pass n rising edges, then settle on the following falling edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset_n     = 1'b0;
    ew_loop_raw = 1'b0;
    emgcy_raw   = 1'b0;
    ew_light    = RED;
    step(2);
    chk("rst_ew_sensor", 32'(ew_sensor), 0);
    chk("rst_emgcy", 32'(emgcy_sensor), 0);
    chk("rst_count", 32'(ew_car_count), 0);
    chk("rst_ovf", 32'(ew_overflow), 0);
    reset_n = 1'b1;

    // T1: bring outputs up, then async reset mid-cycle
    ew_loop_raw = 1'b1;
    emgcy_raw   = 1'b1;
    step(7);
    chk("t1_pre_ew", 32'(ew_sensor), 1);
    chk("t1_pre_em", 32'(emgcy_sensor), 1);
    chk("t1_pre_count", 32'(ew_car_count), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t1_async_ew", 32'(ew_sensor), 0);
    chk("t1_async_em", 32'(emgcy_sensor), 0);
    chk("t1_async_count", 32'(ew_car_count), 0);
    step(2);
    reset_n = 1'b1;
    step(6);
    chk("t1_rel_ew_early", 32'(ew_sensor), 0);
    chk("t1_rel_em_early", 32'(emgcy_sensor), 0);
    step(1);
    chk("t1_rel_ew", 32'(ew_sensor), 1);
    chk("t1_rel_em", 32'(emgcy_sensor), 1);
    chk("t1_rel_count", 32'(ew_car_count), 1);
    ew_loop_raw = 1'b0;
    emgcy_raw   = 1'b0;
    step(20);
    chk("t1_em_quiet", 32'(emgcy_sensor), 0);
    chk("t1_ew_kept", 32'(ew_sensor), 1);
    ew_light = GREEN;
    step(1);
    chk("t1_green_ew", 32'(ew_sensor), 0);
    chk("t1_green_count", 32'(ew_car_count), 0);
    ew_light = RED;
    step(2);

    // T2: 3-cycle glitch is rejected, 10-cycle pulse registers at edge 6
    ew_loop_raw = 1'b1;
    step(3);
    ew_loop_raw = 1'b0;
    step(10);
    chk("t2_glitch_ew", 32'(ew_sensor), 0);
    chk("t2_glitch_count", 32'(ew_car_count), 0);
    ew_loop_raw = 1'b1;
    step(6);
    chk("t2_edge5_ew", 32'(ew_sensor), 0);
    step(1);
    chk("t2_edge6_ew", 32'(ew_sensor), 1);
    chk("t2_edge6_count", 32'(ew_car_count), 1);
    step(3);
    ew_loop_raw = 1'b0;
    step(10);
    chk("t2_after_fall_ew", 32'(ew_sensor), 1);

    // T3: service on green; arrival processed in the green cycle is dropped
    ew_light = GREEN;
    step(1);
    chk("t3_serve_ew", 32'(ew_sensor), 0);
    chk("t3_serve_count", 32'(ew_car_count), 0);
    ew_light    = RED;
    ew_loop_raw = 1'b1;
    step(6);
    ew_light = GREEN;
    step(1);
    chk("t3_same_cycle_ew", 32'(ew_sensor), 0);
    chk("t3_same_cycle_count", 32'(ew_car_count), 0);
    ew_light = RED;
    step(5);
    chk("t3_held_no_req", 32'(ew_sensor), 0);
    chk("t3_held_count", 32'(ew_car_count), 0);
    ew_loop_raw = 1'b0;
    step(10);

    // T4: 15 cars fill the counter, the 16th sets overflow
    for (int i = 0; i < 15; i++) begin
      ew_loop_raw = 1'b1;
      step(8);
      ew_loop_raw = 1'b0;
      step(8);
    end
    chk("t4_count15", 32'(ew_car_count), 15);
    chk("t4_no_ovf", 32'(ew_overflow), 0);
    chk("t4_ew_req", 32'(ew_sensor), 1);
    ew_loop_raw = 1'b1;
    step(8);
    ew_loop_raw = 1'b0;
    step(8);
    chk("t4_sat_count", 32'(ew_car_count), 15);
    chk("t4_ovf", 32'(ew_overflow), 1);
    ew_light = GREEN;
    step(1);
    chk("t4_clr_count", 32'(ew_car_count), 0);
    chk("t4_clr_ovf", 32'(ew_overflow), 0);
    chk("t4_clr_ew", 32'(ew_sensor), 0);

    // T5: emergency with the 8-cycle hold, while EW is green
    emgcy_raw = 1'b1;
    step(6);
    chk("t5_em_edge5", 32'(emgcy_sensor), 0);
    step(1);
    chk("t5_em_edge6", 32'(emgcy_sensor), 1);
    step(13);
    emgcy_raw = 1'b0;
    step(15);
    chk("t5_hold_last", 32'(emgcy_sensor), 1);
    step(1);
    chk("t5_hold_done", 32'(emgcy_sensor), 0);
    ew_light = RED;

    // T6: re-trigger during HOLD keeps the output high, next fall holds fully
    emgcy_raw = 1'b1;
    step(20);
    chk("t6_active", 32'(emgcy_sensor), 1);
    emgcy_raw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk("t6_fall_phase", 32'(emgcy_sensor), 1);
    end
    emgcy_raw = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(1);
      chk("t6_retrig_phase", 32'(emgcy_sensor), 1);
    end
    emgcy_raw = 1'b0;
    step(15);
    chk("t6_full_hold_last", 32'(emgcy_sensor), 1);
    step(1);
    chk("t6_full_hold_done", 32'(emgcy_sensor), 0);
    chk("t6_ew_idle", 32'(ew_sensor), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
